// File: rtl/seq_det_ctrl_if.sv
// -----------------------------------------------------------------------------
// seq_det_ctrl_if
// Pattern configuration handshake between a pattern source and seq_det_ctrl.
//   cfg_valid    source -> controller   new pattern offered
//   cfg_ready    controller -> source   controller can accept a pattern
//   cfg_pattern  source -> controller   PAT_W-bit pattern, consumed LSB first
// Modports: master = pattern source, slave = controller.
// -----------------------------------------------------------------------------
interface seq_det_ctrl_if #(
   parameter int PAT_W = 8
) ();

   logic             cfg_valid;
   logic             cfg_ready;
   logic [PAT_W-1:0] cfg_pattern;

   modport master (
      output cfg_valid,
      output cfg_pattern,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid,
      input  cfg_pattern,
      output cfg_ready
   );

endinterface : seq_det_ctrl_if

// File: rtl/seq_det_ctrl.sv
// -----------------------------------------------------------------------------
// seq_det_ctrl
// Sequencing controller for the serial sequence detector on the CAN receive
// path. A pattern accepted on the cfg handshake is captured, the detector is
// cleared and the pattern shifted in LSB first. The detector is then armed and,
// while search_en is high, fed the qualified receive bitstream. Matches are
// counted (saturating) and an optional search window raises a timeout when
// WIN_LEN valid bits pass without a match. A new pattern may be accepted in
// IDLE, ARM or SEARCH; in SEARCH it aborts the search.
//
// Ports
//   clk, rst_n    clock; synchronous active-low reset
//   cfg           pattern handshake (slave modport of seq_det_ctrl_if)
//   search_en     permit SEARCH; low parks the controller in ARM
//   rx_bit        receive bitstream data
//   rx_bit_vld    rx_bit qualifier, one per sample point
//   det_clr       detector clear pulse
//   det_load      detector load-mode select
//   det_din       serial bit to detector (pattern in LOAD, rx_bit in SEARCH)
//   det_en        detector bit-advance strobe
//   det_dout      detector match flag, honoured only in SEARCH
//   match_pulse   one-cycle pulse, one cycle after det_dout seen in SEARCH
//   match_count   matches since the last accepted pattern, saturating
//   timeout       one-cycle pulse on search-window expiry
//   busy          high in CLEAR and LOAD
// -----------------------------------------------------------------------------
module seq_det_ctrl #(
   parameter int PAT_W   = 8,
   parameter int CNT_W   = 8,
   parameter int WIN_LEN = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   seq_det_ctrl_if.slave    cfg,
   input  logic             search_en,
   input  logic             rx_bit,
   input  logic             rx_bit_vld,
   output logic             det_clr,
   output logic             det_load,
   output logic             det_din,
   output logic             det_en,
   input  logic             det_dout,
   output logic             match_pulse,
   output logic [CNT_W-1:0] match_count,
   output logic             timeout,
   output logic             busy
);

   localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
   localparam int WIN_W = (WIN_LEN > 0) ? $clog2(WIN_LEN + 1) : 1;

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_W - 1);
   // Last count value before expiry; unused when the window is disabled.
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'((WIN_LEN > 0) ? WIN_LEN - 1 : 0);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CLEAR  = 3'd1,
      S_LOAD   = 3'd2,
      S_ARM    = 3'd3,
      S_SEARCH = 3'd4
   } state_e;

   state_e           state_q,   state_d;
   logic [PAT_W-1:0] pat_q,     pat_d;
   logic [IDX_W-1:0] idx_q,     idx_d;
   logic [WIN_W-1:0] win_q,     win_d;
   logic [CNT_W-1:0] cnt_q,     cnt_d;
   logic             match_q,   match_d;
   logic             timeout_q, timeout_d;
   logic             cfg_ready_c;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of its _d signal, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         pat_q     <= '0;
         idx_q     <= '0;
         win_q     <= '0;
         cnt_q     <= '0;
         match_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pat_q     <= pat_d;
         idx_q     <= idx_d;
         win_q     <= win_d;
         cnt_q     <= cnt_d;
         match_q   <= match_d;
         timeout_q <= timeout_d;
      end
   end

   // NOTE: every signal written here is given a default first, so no path
   // through the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      pat_d       = pat_q;
      idx_d       = idx_q;
      win_d       = win_q;
      cnt_d       = cnt_q;
      match_d     = 1'b0;
      timeout_d   = 1'b0;
      cfg_ready_c = 1'b0;
      det_clr     = 1'b0;
      det_load    = 1'b0;
      det_en      = 1'b0;
      det_din     = 1'b0;
      busy        = 1'b0;

      case (state_q)
         S_IDLE: begin
            cfg_ready_c = 1'b1;
            idx_d       = '0;
            win_d       = '0;
         end

         S_CLEAR: begin
            det_clr = 1'b1;
            busy    = 1'b1;
            idx_d   = '0;
            state_d = S_LOAD;
         end

         S_LOAD: begin
            det_load = 1'b1;
            det_en   = 1'b1;
            det_din  = pat_q[idx_q];
            busy     = 1'b1;
            if (idx_q == IDX_LAST) begin
               idx_d   = '0;
               state_d = S_ARM;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end

         S_ARM: begin
            cfg_ready_c = 1'b1;
            win_d       = '0;   // window starts fresh on every SEARCH entry
            if (search_en) begin
               state_d = S_SEARCH;
            end
         end

         S_SEARCH: begin
            cfg_ready_c = 1'b1;
            det_din     = rx_bit;
            det_en      = rx_bit_vld;
            if (det_dout) begin
               // A match also restarts the window, so a match on the
               // expiring bit suppresses the timeout.
               match_d = 1'b1;
               win_d   = '0;
               if (cnt_q != '1) begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else if ((WIN_LEN > 0) && rx_bit_vld) begin
               if (win_q == WIN_LAST) begin
                  timeout_d = 1'b1;
                  win_d     = '0;
                  state_d   = S_ARM;
               end else begin
                  win_d = win_q + 1'b1;
               end
            end
            // Leaving SEARCH still keeps a match sampled in this cycle.
            if (!search_en) begin
               state_d = S_ARM;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Pattern acceptance overrides everything above, including a match or
      // window expiry in the same SEARCH cycle.
      if (cfg_ready_c && cfg.cfg_valid) begin
         pat_d     = cfg.cfg_pattern;
         cnt_d     = '0;
         idx_d     = '0;
         win_d     = '0;
         match_d   = 1'b0;
         timeout_d = 1'b0;
         state_d   = S_CLEAR;
      end
   end

   assign cfg.cfg_ready = cfg_ready_c;
   assign match_pulse   = match_q;
   assign match_count   = cnt_q;
   assign timeout       = timeout_q;

endmodule : seq_det_ctrl

// File: tb/tb_seq_det_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seq_det_ctrl
// Directed bench for seq_det_ctrl (PAT_W=8, CNT_W=2, WIN_LEN=16) with a
// behavioural model of the serial sequence detector attached to the det_*
// signals. Per-cycle detector-interface expectations for the two pattern
// loads are kept in a vector table; streaming, saturation, window and reset
// corner cases are written out as sequences.
// -----------------------------------------------------------------------------
module tb_seq_det_ctrl;

   localparam int PAT_W   = 8;
   localparam int CNT_W   = 2;
   localparam int WIN_LEN = 16;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             search_en;
   logic             rx_bit;
   logic             rx_bit_vld;
   logic             det_clr;
   logic             det_load;
   logic             det_din;
   logic             det_en;
   logic             det_dout;
   logic             match_pulse;
   logic [CNT_W-1:0] match_count;
   logic             timeout;
   logic             busy;

   always #5 clk = ~clk;

   seq_det_ctrl_if #(.PAT_W(PAT_W)) cfg_if ();

   seq_det_ctrl #(
      .PAT_W   (PAT_W),
      .CNT_W   (CNT_W),
      .WIN_LEN (WIN_LEN)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cfg         (cfg_if.slave),
      .search_en   (search_en),
      .rx_bit      (rx_bit),
      .rx_bit_vld  (rx_bit_vld),
      .det_clr     (det_clr),
      .det_load    (det_load),
      .det_din     (det_din),
      .det_en      (det_en),
      .det_dout    (det_dout),
      .match_pulse (match_pulse),
      .match_count (match_count),
      .timeout     (timeout),
      .busy        (busy)
   );

   // Detector model: load mode shifts the pattern in, run mode shifts data in
   // and flags a match for one cycle when the updated window equals the pattern.
   logic [7:0] mdl_pat   = '0;
   logic [7:0] mdl_sr    = '0;
   logic       mdl_match = 1'b0;

   always_ff @(posedge clk) begin
      if (det_clr) begin
         mdl_pat   <= '0;
         mdl_sr    <= '0;
         mdl_match <= 1'b0;
      end else if (det_en && det_load) begin
         mdl_pat   <= {det_din, mdl_pat[7:1]};
         mdl_match <= 1'b0;
      end else if (det_en) begin
         mdl_sr    <= {det_din, mdl_sr[7:1]};
         mdl_match <= ({det_din, mdl_sr[7:1]} == mdl_pat);
      end else begin
         mdl_match <= 1'b0;
      end
   end

   assign det_dout = mdl_match;

   // Detector-side outputs observed as one vector:
   // {det_clr, det_load, det_en, det_din, busy, cfg_ready}
   logic [5:0] obs;
   assign obs = {det_clr, det_load, det_en, det_din, busy, cfg_if.cfg_ready};

   int checks   = 0;
   int failures = 0;
   int pulses   = 0;
   int timeouts = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Advance one clock and sample just after the edge; tally pulse outputs.
   task automatic tick();
      @(posedge clk);
      #1;
      if (match_pulse === 1'b1) pulses++;
      if (timeout === 1'b1) timeouts++;
   endtask

   task automatic send_bit(input logic b);
      rx_bit     = b;
      rx_bit_vld = 1'b1;
      tick();
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int i = 0; i < 8; i++) send_bit(v[i]);
   endtask

   typedef struct {
      string      name;
      logic       cfg_valid;
      logic [7:0] pat;
      logic       search_en;
      logic       rx_bit;
      logic       rx_vld;
      logic [5:0] exp;   // obs expected after the clock edge
   } vec_t;

   vec_t vecs [0:20];

   task automatic run_rows(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         cfg_if.cfg_valid   = vecs[i].cfg_valid;
         cfg_if.cfg_pattern = vecs[i].pat;
         search_en          = vecs[i].search_en;
         rx_bit             = vecs[i].rx_bit;
         rx_bit_vld         = vecs[i].rx_vld;
         tick();
         check(vecs[i].name, obs, vecs[i].exp);
      end
   endtask

   initial begin
      // Load of 8'hA5 from IDLE: bits LSB first 1,0,1,0,0,1,0,1.
      // cfg_pattern is changed after the handshake; it must not matter.
      vecs[0]  = '{"a5_clear",  1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 6'b100010};
      vecs[1]  = '{"a5_load0",  1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 6'b011110};
      vecs[2]  = '{"a5_load1",  1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 6'b011010};
      vecs[3]  = '{"a5_load2",  1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 6'b011110};
      vecs[4]  = '{"a5_load3",  1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 6'b011010};
      vecs[5]  = '{"a5_load4",  1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 6'b011010};
      vecs[6]  = '{"a5_load5",  1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 6'b011110};
      vecs[7]  = '{"a5_load6",  1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 6'b011010};
      vecs[8]  = '{"a5_load7",  1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 6'b011110};
      vecs[9]  = '{"a5_arm",    1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 6'b000001};
      // ARM with search_en low ignores valid receive bits.
      vecs[10] = '{"a5_park",   1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 6'b000001};
      // Re-program 8'h3C from SEARCH: bits LSB first 0,0,1,1,1,1,0,0.
      vecs[11] = '{"3c_clear",  1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 6'b100010};
      vecs[12] = '{"3c_load0",  1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 6'b011010};
      vecs[13] = '{"3c_load1",  1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 6'b011010};
      vecs[14] = '{"3c_load2",  1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 6'b011110};
      vecs[15] = '{"3c_load3",  1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 6'b011110};
      vecs[16] = '{"3c_load4",  1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 6'b011110};
      vecs[17] = '{"3c_load5",  1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 6'b011110};
      vecs[18] = '{"3c_load6",  1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 6'b011010};
      vecs[19] = '{"3c_load7",  1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 6'b011010};
      vecs[20] = '{"3c_arm",    1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 6'b000001};

      // ---- reset state ----
      rst_n              = 1'b0;
      cfg_if.cfg_valid   = 1'b0;
      cfg_if.cfg_pattern = '0;
      search_en          = 1'b0;
      rx_bit             = 1'b0;
      rx_bit_vld         = 1'b0;
      tick();
      tick();
      check("reset_obs", obs, 6'b000001);
      check("reset_match_pulse", match_pulse, 1'b0);
      check("reset_timeout", timeout, 1'b0);
      check("reset_count", match_count, 0);
      rst_n = 1'b1;
      tick();
      check("idle_obs", obs, 6'b000001);

      // ---- load 8'hA5 ----
      run_rows(0, 10);

      // ---- search and first match ----
      rx_bit_vld = 1'b0;
      search_en  = 1'b1;
      tick();                       // now in SEARCH
      check("search_ready", cfg_if.cfg_ready, 1'b1);
      pulses = 0;
      send_byte(8'hA5);
      rx_bit_vld = 1'b0;
      check("det_dout_seen", det_dout, 1'b1);
      check("pulse_not_early", match_pulse, 1'b0);
      tick();
      check("pulse_latency1", match_pulse, 1'b1);
      check("count_after_first", match_count, 1);
      tick();
      check("pulse_one_cycle", match_pulse, 1'b0);

      // ---- saturation: five more matches on a 2-bit counter ----
      pulses   = 0;
      timeouts = 0;
      for (int m = 0; m < 5; m++) send_byte(8'hA5);
      rx_bit_vld = 1'b0;
      tick();
      tick();
      tick();
      check("sat_pulses", pulses, 5);
      check("sat_count", match_count, 3);
      check("sat_no_timeout", timeouts, 0);

      // ---- window expiry after 16 non-matching bits ----
      timeouts = 0;
      for (int b = 0; b < 15; b++) send_bit(1'b0);
      check("win_no_early_timeout", timeouts, 0);
      send_bit(1'b0);               // 16th bit; rx_bit_vld stays high
      check("win_timeout", timeout, 1'b1);
      check("win_in_arm", obs, 6'b000001);
      check("win_count_kept", match_count, 3);
      rx_bit_vld = 1'b0;
      tick();                       // back to SEARCH (search_en still high)
      check("win_timeout_one_cycle", timeout, 1'b0);

      // ---- match on the expiring bit beats the timeout ----
      pulses   = 0;
      timeouts = 0;
      for (int b = 0; b < 7; b++) send_bit(1'b0);
      send_byte(8'hA5);             // completes on bit 15
      send_bit(1'b0);               // bit 16: det_dout high, window full
      rx_bit_vld = 1'b0;
      tick();
      tick();
      check("tie_match_pulse", pulses, 1);
      check("tie_no_timeout", timeouts, 0);

      // ---- re-program mid-SEARCH with 8'h3C ----
      check("mid_search_ready", cfg_if.cfg_ready, 1'b1);
      run_rows(11, 11);
      check("reprog_count_cleared", match_count, 0);
      run_rows(12, 20);

      // The reloaded detector now matches 8'h3C.
      search_en = 1'b1;
      tick();
      pulses = 0;
      send_byte(8'h3C);
      rx_bit_vld = 1'b0;
      tick();
      tick();
      check("3c_match_pulses", pulses, 1);
      check("3c_count", match_count, 1);
      search_en = 1'b0;
      tick();
      check("3c_back_to_arm", obs, 6'b000001);

      // ---- reset on the 4th LOAD cycle ----
      cfg_if.cfg_valid   = 1'b1;
      cfg_if.cfg_pattern = 8'hFF;
      tick();                       // CLEAR
      cfg_if.cfg_valid = 1'b0;
      tick();                       // LOAD 1
      tick();                       // LOAD 2
      tick();                       // LOAD 3
      tick();                       // LOAD 4
      check("pre_reset_in_load", obs, 6'b011110);
      rst_n = 1'b0;
      tick();
      check("midload_reset_obs", obs, 6'b000001);
      check("midload_reset_count", match_count, 0);
      rst_n = 1'b1;
      tick();
      check("post_reset_idle", obs, 6'b000001);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_seq_det_ctrl
